// File: rtl/bias_buffer.sv
// Bias word buffer: a full-table load port fills WORD_AMOUNT words, then a read request
//   streams rd_len words starting at rd_base, wrapping past the last address back to 0.
// Latency: the first stream word is valid two edges after rd_start is sampled, then one word per cycle.
// Backpressure: out_ready low freezes the output register and stalls the read pipeline; ld_ready is high only in LOAD.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ld_start                       begin a full-table load at address 0 (IDLE only)
//   ld_valid, ld_data, ld_ready    load word handshake
//   ld_done                        one-cycle pulse after the final load word is written
//   rd_start, rd_base, rd_len      request a stream of rd_len words from rd_base (IDLE only)
//   out_valid, out_data, out_last  output stream, out_last marks the final word
//   out_ready                      downstream accept
//   busy                           high whenever the block is not IDLE
module bias_buffer #(
    parameter int WORD_AMOUNT  = 48,
    parameter int BIT_PER_WORD = 17,
    localparam int AW          = $clog2(WORD_AMOUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_start,
    input  logic                    ld_valid,
    input  logic [BIT_PER_WORD-1:0] ld_data,
    output logic                    ld_ready,
    output logic                    ld_done,
    input  logic                    rd_start,
    input  logic [AW-1:0]           rd_base,
    input  logic [AW:0]             rd_len,
    output logic                    out_valid,
    output logic [BIT_PER_WORD-1:0] out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [AW:0]   WA_LEN    = (AW+1)'(WORD_AMOUNT);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORD_AMOUNT - 1);

    state_t state, state_nxt;

    logic [BIT_PER_WORD-1:0] mem [WORD_AMOUNT];

    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             len_q;
    logic [AW:0]             iss_cnt;

    // Read stage between the memory and the output register.
    logic                    s1_vld;
    logic [BIT_PER_WORD-1:0] s1_dat;
    logic                    s1_last;

    logic                    wr_fire;
    logic                    rd_accept;
    logic                    out_take;
    logic                    s1_adv;
    logic                    s1_free;
    logic                    issue;
    logic [AW:0]             base_ext;
    logic [AW-1:0]           base_mod;
    logic [AW:0]             len_clamp;

    // ld_ready is a registered copy of "in LOAD", so this is exactly a LOAD-state handshake.
    assign wr_fire   = ld_valid && ld_ready;
    // ld_start has priority; a zero-length read is not a request at all.
    assign rd_accept = (state == IDLE) && !ld_start && rd_start && (rd_len != '0);

    // 2**AW < 2*WORD_AMOUNT, so a single conditional subtract reduces any base into range.
    assign base_ext  = {1'b0, rd_base};
    assign base_mod  = (base_ext >= WA_LEN) ? AW'(base_ext - WA_LEN) : rd_base;
    assign len_clamp = (rd_len > WA_LEN) ? WA_LEN : rd_len;

    // The output register may reload when empty or when its word is being taken.
    assign out_take = !out_valid || out_ready;
    assign s1_adv   = s1_vld && out_take;
    assign s1_free  = !s1_vld || s1_adv;
    assign issue    = (state == STREAM) && (iss_cnt < len_q) && s1_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_nxt = LOAD;
                end else if (rd_start && (rd_len != '0)) begin
                    state_nxt = STREAM;
                end
            end
            LOAD: begin
                if (wr_fire && (wr_ptr == LAST_ADDR)) begin
                    state_nxt = IDLE;
                end
            end
            STREAM: begin
                if (out_valid && out_ready && out_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage has no reset so table contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            ld_ready  <= 1'b0;
            ld_done   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            len_q     <= '0;
            iss_cnt   <= '0;
            s1_vld    <= 1'b0;
            s1_dat    <= '0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            busy     <= (state_nxt != IDLE);
            ld_ready <= (state_nxt == LOAD);
            ld_done  <= wr_fire && (wr_ptr == LAST_ADDR);

            if ((state == IDLE) && ld_start) begin
                wr_ptr <= '0;
            end else if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (rd_accept) begin
                rd_ptr  <= base_mod;
                len_q   <= len_clamp;
                iss_cnt <= '0;
            end else if (issue) begin
                rd_ptr  <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
                iss_cnt <= iss_cnt + 1'b1;
            end

            if (issue) begin
                s1_vld  <= 1'b1;
                s1_dat  <= mem[rd_ptr];
                s1_last <= (iss_cnt == len_q - 1'b1);
            end else if (s1_adv) begin
                s1_vld  <= 1'b0;
            end

            if (out_take) begin
                out_valid <= s1_vld;
                out_data  <= s1_vld ? s1_dat : '0;
                out_last  <= s1_vld && s1_last;
            end
        end
    end

endmodule

// File: tb/tb_bias_buffer.sv
// Directed bench for bias_buffer: table model plus expected-word queue, checked every cycle.
module tb_bias_buffer;

    localparam int WA = 48;
    localparam int BW = 17;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_start;
    logic          ld_valid;
    logic [BW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_done;
    logic          rd_start;
    logic [AW-1:0] rd_base;
    logic [AW:0]   rd_len;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          busy;

    bias_buffer #(.WORD_AMOUNT(WA), .BIT_PER_WORD(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .rd_start  (rd_start),
        .rd_base   (rd_base),
        .rd_len    (rd_len),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] model_mem [WA];
    logic [BW-1:0] exp_q [$];
    bit            exp_last_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Expected words for a read, straight from the table: address (base+i) mod WA, length clamped.
    task automatic push_model(input int base, input int len);
        int eff;
        eff = (len > WA) ? WA : len;
        for (int i = 0; i < eff; i++) begin
            exp_q.push_back(model_mem[(base + i) % WA]);
            exp_last_q.push_back(i == eff - 1);
        end
    endtask

    task automatic push_lit(input int val, input bit last);
        exp_q.push_back(BW'(val));
        exp_last_q.push_back(last);
    endtask

    // Every accepted word must be the next expected one; stalled words must hold.
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_dat;
    logic          prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_data", out_data, prev_dat);
                check("stall_hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got data %0d, required no word", out_data);
                end else begin
                    logic [BW-1:0] e;
                    bit            l;
                    e = exp_q.pop_front();
                    l = exp_last_q.pop_front();
                    check("stream_data", out_data, e);
                    check("stream_last", out_last, l);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_dat   = out_data;
            prev_last  = out_last;
        end
    end

    task automatic do_load(input bit also_rd);
        int writes = 0;
        int dones  = 0;
        int after  = 0;
        ld_start = 1'b1;
        rd_start = also_rd;
        rd_base  = '0;
        rd_len   = 7'd4;
        @(posedge clk); #1;
        ld_start = 1'b0;
        rd_start = 1'b0;
        check("load_busy", busy, 1);
        check("load_ready", ld_ready, 1);
        for (int cyc = 0; cyc < 300 && after < 3; cyc++) begin
            ld_valid = (cyc % 3) != 2;
            ld_data  = BW'(100 + writes);
            rd_start = (cyc == 10);
            @(negedge clk);
            if (ld_valid && ld_ready) begin
                model_mem[writes % WA] = ld_data;
                writes++;
            end
            if (ld_done) begin
                dones++;
                check("done_busy_low", busy, 0);
                check("done_ready_low", ld_ready, 0);
            end
            if (dones > 0) after++;
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        rd_start = 1'b0;
        check("load_writes", writes, 48);
        check("load_done_pulses", dones, 1);
    endtask

    task automatic start_stream(input int base, input int len);
        rd_base  = AW'(base);
        rd_len   = (AW+1)'(len);
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        check("lat_edge_n", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge_n1", out_valid, 0);
        check("busy_stream", busy, 1);
        @(posedge clk); #1;
        check("lat_edge_n2", out_valid, 1);
    endtask

    task automatic drain(input bit rnd);
        bit done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (exp_q.size() == 0) done = 1'b1;
            else if (!rnd) check("no_bubble", out_valid, 1);
        end
        out_ready = 1'b1;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words pending, required 0", exp_q.size());
        end
        check("end_valid_low", out_valid, 0);
        check("end_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        rd_start  = 1'b0;
        rd_base   = '0;
        rd_len    = '0;
        out_ready = 1'b1;
        #1;
        check("reset_busy", busy, 0);
        check("reset_ld_ready", ld_ready, 0);
        check("reset_ld_done", ld_done, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_data", out_data, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Gapped full load, rd_start mid-load is ignored.
        do_load(1'b0);

        // Full-table stream, no bubbles, last only on 147.
        push_model(0, 48);
        start_stream(0, 48);
        drain(1'b0);

        // Wrap-around, literal expectations.
        push_lit(145, 0); push_lit(146, 0); push_lit(147, 0);
        push_lit(100, 0); push_lit(101, 0); push_lit(102, 1);
        start_stream(45, 6);
        drain(1'b0);

        // Random backpressure.
        push_model(20, 8);
        start_stream(20, 8);
        drain(1'b1);

        // ld_start and rd_start together: load wins, no stream.
        do_load(1'b1);

        // Zero-length read does nothing.
        rd_base  = 6'd3;
        rd_len   = '0;
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("len0_busy", busy, 0);
            check("len0_valid", out_valid, 0);
            @(posedge clk); #1;
        end

        // Oversized length is clamped to the table size.
        push_model(5, 60);
        start_stream(5, 60);
        drain(1'b0);

        // Reset in the middle of a stream.
        push_model(0, 10);
        start_stream(0, 10);
        for (int c = 0; c < 50 && exp_q.size() > 7; c++) begin
            @(posedge clk); #1;
        end
        check("mid_words_taken", exp_q.size(), 7);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_last", out_last, 0);
        check("arst_busy", busy, 0);
        check("arst_ld_ready", ld_ready, 0);
        check("arst_ld_done", ld_done, 0);
        exp_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_lit(100, 0);
        push_lit(101, 1);
        start_stream(0, 2);
        drain(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bias_buffer.md
BIAS_BUFFER -- requirements
Module: bias_buffer

Interface
REQ-001 Parameter WORD_AMOUNT, default 48, SHALL set the number of bias words stored.
REQ-002 Parameter BIT_PER_WORD, default 17, SHALL set the width of each bias word.
REQ-003 Localparam AW = $clog2(WORD_AMOUNT) SHALL set the address width; it is derived and not overridable.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 ld_start  in  1  SHALL request a full-table load starting at address 0.
REQ-007 ld_valid  in  1 / ld_data  in  BIT_PER_WORD  SHALL carry the load word; ld_ready  out  1  SHALL accept it.
REQ-008 ld_done  out  1  SHALL be a one-cycle pulse marking load completion.
REQ-009 rd_start  in  1 / rd_base  in  AW / rd_len  in  AW+1  SHALL request a stream of rd_len words from rd_base.
REQ-010 out_valid  out  1 / out_data  out  BIT_PER_WORD / out_last  out  1 / out_ready  in  1  SHALL form the output stream.
REQ-011 busy  out  1  SHALL be high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD and STREAM.
REQ-013 In IDLE, ld_start SHALL enter LOAD; rd_start with rd_len != 0 SHALL enter STREAM; if both are asserted, ld_start SHALL win and rd_start SHALL be dropped.
REQ-014 rd_start with rd_len == 0 SHALL be ignored (remain IDLE); rd_len > WORD_AMOUNT SHALL be clamped to WORD_AMOUNT.
REQ-015 ld_start and rd_start SHALL be ignored outside IDLE.
REQ-016 In LOAD, ld_ready SHALL be 1; elsewhere it SHALL be 0.
REQ-017 Each ld_valid && ld_ready cycle SHALL write ld_data to the write pointer (starting at 0), then increment the pointer.
REQ-018 The write to address WORD_AMOUNT-1 SHALL end LOAD: next cycle ld_done=1 for one cycle, and state is IDLE.
REQ-019 Stream address i SHALL be (rd_base + i) mod WORD_AMOUNT for i = 0..len-1, wrapping past WORD_AMOUNT-1 to 0.
REQ-020 If rd_start is sampled at edge N, the first word SHALL appear with out_valid=1 after edge N+2.
REQ-021 With out_ready held 1, the stream SHALL sustain one word per cycle with no bubbles.
REQ-022 While out_valid && !out_ready, out_data, out_last and out_valid SHALL hold stable; no word SHALL be dropped or duplicated.
REQ-023 A word SHALL transfer on out_valid && out_ready.
REQ-024 out_last SHALL be 1 exactly with the len-th word.
REQ-025 The cycle after the last transfer, out_valid SHALL be 0 and state SHALL be IDLE.
REQ-026 Memory SHALL be uninitialised storage with one write and one read per cycle (no reset of contents).
REQ-027 Reads of never-written addresses SHALL be unspecified and are not checked.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 When rst_n=0, state SHALL be IDLE, and busy, ld_ready, ld_done, out_valid, out_last and out_data SHALL be 0 immediately, without waiting for clk.
REQ-030 Reset mid-LOAD or mid-STREAM SHALL abort the operation and discard any pending stream words.
REQ-031 Memory contents SHALL be retained across reset.
REQ-032 After rst_n rises, the first rising edge SHALL accept a new start.

Verification
REQ-033 Load 48 words (value = 100 + addr) with ld_valid gapped every third cycle -> exactly 48 writes, ld_done pulses once, busy falls the same cycle.
REQ-034 rd_base=0, rd_len=48, out_ready=1 -> 48 words 100..147 on consecutive cycles, first at edge N+2, out_last only on 147.
REQ-035 rd_base=45, rd_len=6 -> stream 145, 146, 147, 100, 101, 102 (wrap-around), out_last on 102.
REQ-036 rd_len=8 with out_ready toggling randomly -> 8 ordered words, data stable during stalls, no loss or duplication.
REQ-037 ld_start and rd_start in the same IDLE cycle -> LOAD entered, no stream; rd_len=0 -> no activity; rd_len=60 -> 48 words.
REQ-038 rst_n pulsed low mid-stream (word 3 of 10) -> outputs 0 asynchronously; after release, re-stream rd_base=0, rd_len=2 -> 100, 101 (memory intact).
